// File: rtl/vcsr_rmw.sv
// vcsr_rmw: virtual-CSR unit. Each of VcsrAmount config registers maps a bit
// field (target address, offset, width) of a real CSR. An access to alias
// address VcsrBase+VcsrAmount+i performs a read-modify-write on that field
// over a request/grant CSR bus while stalling the core.
//
// Optional feature macro: VCSR_LOCK_EN (config bit 31 becomes a sticky lock bit).
//
// Ports:
//   clk, reset (async active-low)
//   csr_enable/csr_addr/csr_op/csr_wdata : core CSR access (op 01 RW, 10 RS, 11 RC)
//   stall                                : combinational core hold during alias access
//   rd_valid/rd_data/err                 : one-cycle response (old config or old field)
//   bus_req/bus_we/bus_addr/bus_wdata    : CSR-bus master request
//   bus_gnt/bus_rvalid/bus_rdata         : CSR-bus slave response
module vcsr_rmw #(
  parameter int unsigned VcsrAmount   = 16,
  parameter int unsigned VcsrBase     = 'h100,
  parameter int unsigned CsrAddrWidth = 12,
  parameter int unsigned DataWidth    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    csr_enable,
  input  logic [CsrAddrWidth-1:0] csr_addr,
  input  logic [1:0]              csr_op,
  input  logic [DataWidth-1:0]    csr_wdata,
  output logic                    stall,
  output logic                    rd_valid,
  output logic [DataWidth-1:0]    rd_data,
  output logic                    err,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [CsrAddrWidth-1:0] bus_addr,
  output logic [DataWidth-1:0]    bus_wdata,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [DataWidth-1:0]    bus_rdata
);

  localparam int unsigned IdxW = (VcsrAmount > 1) ? $clog2(VcsrAmount) : 1;
  localparam logic [CsrAddrWidth-1:0] BaseA = CsrAddrWidth'(VcsrBase);
  localparam logic [CsrAddrWidth-1:0] AmtA  = CsrAddrWidth'(VcsrAmount);
  localparam logic [CsrAddrWidth-1:0] Amt2A = CsrAddrWidth'(2 * VcsrAmount);
`ifdef VCSR_LOCK_EN
  localparam logic [31:0] CfgWrMask = 32'h803F_FFFF;
`else
  localparam logic [31:0] CfgWrMask = 32'h003F_FFFF;
`endif
  localparam logic [1:0] OpNone = 2'b00;
  localparam logic [1:0] OpRw   = 2'b01;
  localparam logic [1:0] OpRs   = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             cfg_q [VcsrAmount];
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [1:0]              op_q, op_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic [DataWidth-1:0]    field_q, field_d;
  logic                    rd_valid_d, err_d, bus_req_d, bus_we_d;
  logic [DataWidth-1:0]    rd_data_d, bus_wdata_d;
  logic [CsrAddrWidth-1:0] bus_addr_d;
  logic                    cfg_we;
  logic [31:0]             cfg_raw, cfg_new;

  // Address decode relative to the config base
  logic [CsrAddrWidth-1:0] off;
  logic                    acc, in_base, cfg_hit, alias_hit;
  logic [IdxW-1:0]         cfg_idx, alias_idx;
  assign off       = csr_addr - BaseA;
  assign acc       = csr_enable && (csr_op != OpNone);
  assign in_base   = csr_addr >= BaseA;
  assign cfg_hit   = acc && in_base && (off < AmtA);
  assign alias_hit = acc && in_base && (off >= AmtA) && (off < Amt2A);
  assign cfg_idx   = IdxW'(off);
  assign alias_idx = IdxW'(off - AmtA);

  // Legality of the channel addressed by an incoming alias access
  logic [31:0]             hit_cfg;
  logic [CsrAddrWidth-1:0] hit_tgt;
  logic                    hit_illegal;
  assign hit_cfg     = cfg_q[alias_idx];
  assign hit_tgt     = CsrAddrWidth'(hit_cfg[11:0]);
  assign hit_illegal = (hit_cfg == 32'd0) ||
                       ((hit_tgt >= BaseA) && ((hit_tgt - BaseA) < Amt2A));

  // Field geometry of the channel being processed
  logic [4:0]           act_off;
  logic [5:0]           act_width;
  logic [DataWidth-1:0] mask, old_field, new_field, wr_bits;
  logic                 skip_wr;
  assign act_off   = cfg_q[idx_q][16:12];
  assign act_width = {1'b0, cfg_q[idx_q][21:17]} + 6'd1;
  assign mask      = DataWidth'(((64'd1 << act_width) - 64'd1) << act_off);
  assign old_field = (bus_rdata & mask) >> act_off;
  assign wr_bits   = (wdata_q << act_off) & mask;
  assign skip_wr   = (op_q != OpRw) && (wr_bits == '0);

  always_comb begin
    unique case (op_q)
      OpRw:    new_field = wdata_q;
      OpRs:    new_field = old_field | wdata_q;
      default: new_field = old_field & ~wdata_q;
    endcase
  end

  // Config register update value for a direct config access
  always_comb begin
    unique case (csr_op)
      OpRw:    cfg_raw = 32'(csr_wdata);
      OpRs:    cfg_raw = cfg_q[cfg_idx] | 32'(csr_wdata);
      default: cfg_raw = cfg_q[cfg_idx] & ~32'(csr_wdata);
    endcase
    cfg_new = cfg_raw & CfgWrMask;
  end

  // Next state and registered-output values
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    field_d     = field_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data;
    err_d       = 1'b0;
    bus_req_d   = 1'b0;
    bus_we_d    = 1'b0;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    stall       = 1'b0;
    cfg_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (alias_hit) begin
          stall   = 1'b1;
          idx_d   = alias_idx;
          op_d    = csr_op;
          wdata_d = csr_wdata;
          if (hit_illegal) begin
            state_d    = DONE;
            rd_valid_d = 1'b1;
            rd_data_d  = '0;
            err_d      = 1'b1;
          end else begin
            state_d    = RD_REQ;
            bus_req_d  = 1'b1;
            bus_addr_d = hit_tgt;
          end
        end else if (cfg_hit) begin
          rd_valid_d = 1'b1;
          rd_data_d  = DataWidth'(cfg_q[cfg_idx]);
`ifdef VCSR_LOCK_EN
          cfg_we     = !cfg_q[cfg_idx][31];
`else
          cfg_we     = 1'b1;
`endif
        end
      end
      RD_REQ: begin
        stall     = 1'b1;
        bus_req_d = 1'b1;
        if (bus_gnt) begin
          state_d   = RD_WAIT;
          bus_req_d = 1'b0;
        end
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          field_d = old_field;
          if (skip_wr) begin
            state_d    = DONE;
            rd_valid_d = 1'b1;
            rd_data_d  = old_field;
          end else begin
            state_d     = WR_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b1;
            bus_wdata_d = (bus_rdata & ~mask) | ((new_field << act_off) & mask);
          end
        end
      end
      WR_REQ: begin
        stall     = 1'b1;
        bus_req_d = 1'b1;
        bus_we_d  = 1'b1;
        if (bus_gnt) begin
          state_d    = DONE;
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          rd_valid_d = 1'b1;
          rd_data_d  = field_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, capture and output registers; reset aborts any access at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      op_q      <= '0;
      wdata_q   <= '0;
      field_q   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      for (int i = 0; i < VcsrAmount; i++) cfg_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      field_q   <= field_d;
      rd_valid  <= rd_valid_d;
      rd_data   <= rd_data_d;
      err       <= err_d;
      bus_req   <= bus_req_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
      if (cfg_we) cfg_q[cfg_idx] <= cfg_new;
    end
  end

endmodule

// File: tb/tb_vcsr_rmw.sv
// Bench for vcsr_rmw: directed scenarios plus randomized traffic against a
// field-level reference model; a response scoreboard and a bus-slave monitor.
module tb_vcsr_rmw;

  localparam int VB = 'h100;
  localparam int N  = 16;
  localparam logic [1:0] RW = 2'b01;
  localparam logic [1:0] RS = 2'b10;
  localparam logic [1:0] RC = 2'b11;

  typedef struct packed {logic err; logic [31:0] data;} resp_t;
  typedef struct packed {logic we; logic [11:0] addr; logic [31:0] data;} bus_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_enable;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic        stall, rd_valid, err, bus_req, bus_we;
  logic [31:0] rd_data, bus_wdata;
  logic [11:0] bus_addr;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int checks = 0;
  int failures = 0;

  resp_t exp_q[$];
  bus_t  bus_exp[$];
  logic [31:0] m_cfg [N];
  logic [31:0] m_mem [4096];
  logic [31:0] slave_mem [4096];

  int gnt_delay = 0;
  int rv_delay = 0;
  int rv_cnt = -1;
  int req_cnt = 0;
  logic [11:0] rd_addr = 12'd0;
  logic [11:0] hold_addr = 12'd0;
  logic        hold_we = 1'b0;
  logic        rd_granted = 1'b0;
  logic        bus_req_seen = 1'b0;
  int          bus_txn = 0;
  int          stall_run = 0;
  int          last_stall = 0;
  logic [31:0] last_rd = 32'd0;

  vcsr_rmw #(.VcsrAmount(N), .VcsrBase(VB), .CsrAddrWidth(12), .DataWidth(32)) dut (
    .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
    .csr_op(csr_op), .csr_wdata(csr_wdata), .stall(stall), .rd_valid(rd_valid),
    .rd_data(rd_data), .err(err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_bus_we"}, 32'(bus_we), 32'd0);
    chk({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
  endtask

  // Reference: direct config access returns old value, then applies the op
  task automatic model_cfg(input int idx, input logic [1:0] op, input logic [31:0] wd);
    logic [31:0] old, nv;
    old = m_cfg[idx];
    exp_q.push_back('{err: 1'b0, data: old});
    case (op)
      RW:      nv = wd;
      RS:      nv = old | wd;
      default: nv = old & ~wd;
    endcase
`ifdef VCSR_LOCK_EN
    if (!old[31]) m_cfg[idx] = nv & 32'h803F_FFFF;
`else
    m_cfg[idx] = nv & 32'h003F_FFFF;
`endif
  endtask

  // Reference: alias access as a field read-modify-write on the model memory
  task automatic model_alias(input int idx, input logic [1:0] op, input logic [31:0] wd);
    logic [31:0] c, old, mask, of, nf, nv;
    logic [11:0] t;
    int off, w;
    longint unsigned m64;
    c = m_cfg[idx];
    t = c[11:0];
    off = int'(c[16:12]);
    w = int'(c[21:17]) + 1;
    m64 = ((64'd1 << w) - 64'd1) << off;
    mask = m64[31:0];
    if (c == 32'd0 || (int'(t) >= VB && int'(t) < VB + 2 * N)) begin
      exp_q.push_back('{err: 1'b1, data: 32'd0});
    end else begin
      old = m_mem[t];
      of = (old & mask) >> off;
      case (op)
        RW:      nf = wd;
        RS:      nf = of | wd;
        default: nf = of & ~wd;
      endcase
      bus_exp.push_back('{we: 1'b0, addr: t, data: 32'd0});
      if (!(op != RW && ((wd << off) & mask) == 32'd0)) begin
        nv = (old & ~mask) | ((nf << off) & mask);
        bus_exp.push_back('{we: 1'b1, addr: t, data: nv});
        m_mem[t] = nv;
      end
      exp_q.push_back('{err: 1'b0, data: of});
    end
  endtask

  // Drive one core CSR access and wait until its response has been scored
  task automatic issue(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    int n;
    @(negedge clk);
    csr_enable = 1'b1; csr_addr = a; csr_op = op; csr_wdata = wd;
    @(negedge clk);
    csr_enable = 1'b0; csr_op = 2'b00;
    n = 0;
    #3;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk); #3; n++;
    end
    if (n >= 400) begin
      checks++; failures++;
      $display("FAIL response_timeout addr=%h actual=no_rd_valid required=rd_valid", a);
      exp_q.delete(); bus_exp.delete();
    end
  endtask

  // Response monitor: pops the scoreboard whenever rd_valid is presented
  always @(negedge clk) begin
    resp_t e;
    #2;
    if (!reset) begin
      stall_run = 0;
    end else begin
      if (stall) stall_run++;
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rd_valid actual=%h required=none", rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("rd_err", 32'(err), 32'(e.err));
        end
        last_rd = rd_data;
        last_stall = stall_run;
        stall_run = 0;
      end else if (err) begin
        checks++; failures++;
        $display("FAIL err_without_rd_valid actual=1 required=0");
      end
    end
  end

  // CSR-file bus slave with configurable grant and read-data latency
  always @(negedge clk) begin
    bus_t be;
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
    if (!reset) begin
      rv_cnt = -1; req_cnt = 0;
    end else begin
      if (rv_cnt == 0) begin
        bus_rvalid = 1'b1; bus_rdata = slave_mem[rd_addr]; rv_cnt = -1;
      end else if (rv_cnt > 0) begin
        rv_cnt--;
      end
      if (bus_req) begin
        bus_req_seen = 1'b1;
        if (req_cnt == 0) begin
          hold_addr = bus_addr; hold_we = bus_we;
        end else begin
          chk("bus_hold_addr", 32'(bus_addr), 32'(hold_addr));
          chk("bus_hold_we", 32'(bus_we), 32'(hold_we));
        end
        if (req_cnt >= gnt_delay) begin
          bus_gnt = 1'b1; req_cnt = 0; bus_txn++;
          if (bus_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL bus_unexpected we=%0b addr=%h required=none", bus_we, bus_addr);
          end else begin
            be = bus_exp.pop_front();
            chk("bus_we", 32'(bus_we), 32'(be.we));
            chk("bus_addr", 32'(bus_addr), 32'(be.addr));
            if (be.we) chk("bus_wdata", bus_wdata, be.data);
          end
          if (bus_we) slave_mem[bus_addr] = bus_wdata;
          else begin rd_addr = bus_addr; rv_cnt = rv_delay; rd_granted = 1'b1; end
        end else begin
          req_cnt++;
        end
      end
    end
  end

  initial begin
    int n, idx, sel;
    logic [11:0] t;
    logic [1:0] op;
    logic [31:0] wd;
    reset = 1'b0; csr_enable = 1'b0; csr_addr = 12'd0; csr_op = 2'b00; csr_wdata = 32'd0;
    for (int i = 0; i < N; i++) m_cfg[i] = 32'd0;
    for (int i = 0; i < 4096; i++) begin
      m_mem[i] = $urandom; slave_mem[i] = m_mem[i];
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1 chk_outputs_zero("in_reset");
    @(negedge clk); reset = 1'b1;
    #1 chk_outputs_zero("after_reset");
    model_cfg(0, RS, 32'd0);
    issue(12'(VB), RS, 32'd0);
    chk("cfg0_reset_read", last_rd, 32'd0);

    // Config RW then RS
    model_cfg(0, RW, 32'h0010_9300); issue(12'(VB), RW, 32'h0010_9300);
    model_cfg(0, RS, 32'h1);         issue(12'(VB), RS, 32'h1);
    chk("cfg_rw_readback", last_rd, 32'h0010_9300);
    model_cfg(0, RS, 32'h0);         issue(12'(VB), RS, 32'h0);
    chk("cfg_rs_readback", last_rd, 32'h0010_9301);
    model_cfg(3, RW, 32'hFFFF_FFFF); issue(12'(VB + 3), RW, 32'hFFFF_FFFF);
    model_cfg(3, RC, 32'h0);         issue(12'(VB + 3), RC, 32'h0);
    chk("cfg_reserved_bits", last_rd, 32'h003F_FFFF);

    // Alias RW, immediate bus
    model_cfg(0, RW, 32'h0006_4300); issue(12'(VB), RW, 32'h0006_4300);
    slave_mem[12'h300] = 32'hFFFF_00F5; m_mem[12'h300] = 32'hFFFF_00F5;
    gnt_delay = 0; rv_delay = 0;
    model_alias(0, RW, 32'hA); issue(12'(VB + N), RW, 32'hA);
    chk("alias_rw_old_field", last_rd, 32'hF);
    chk("alias_stall_cycles", 32'(last_stall), 32'd4);
    chk("alias_target_written", slave_mem[12'h300], 32'hFFFF_00A5);

    // RC with zero wdata: read only
    bus_txn = 0;
    model_alias(0, RC, 32'h0); issue(12'(VB + N), RC, 32'h0);
    chk("rc_zero_bus_txns", 32'(bus_txn), 32'd1);
    chk("rc_zero_old_field", last_rd, 32'hA);

    // Illegal aliases: zero config and target in VCSR range
    bus_req_seen = 1'b0;
    model_alias(1, RW, 32'h3); issue(12'(VB + N + 1), RW, 32'h3);
    chk("zero_cfg_no_bus_req", 32'(bus_req_seen), 32'd0);
    model_cfg(2, RW, 32'h0000_0105); issue(12'(VB + 2), RW, 32'h0000_0105);
    bus_req_seen = 1'b0;
    model_alias(2, RS, 32'h1); issue(12'(VB + N + 2), RS, 32'h1);
    chk("vcsr_target_no_bus_req", 32'(bus_req_seen), 32'd0);

    // Delayed grant, then reset in RD_WAIT
    gnt_delay = 3; rv_delay = 1000; rd_granted = 1'b0;
    bus_exp.push_back('{we: 1'b0, addr: 12'h300, data: 32'd0});
    @(negedge clk);
    csr_enable = 1'b1; csr_addr = 12'(VB + N); csr_op = RW; csr_wdata = 32'h5;
    @(negedge clk);
    csr_enable = 1'b0; csr_op = 2'b00;
    n = 0;
    #1;
    while (!rd_granted && n < 50) begin @(negedge clk); #1; n++; end
    chk("delayed_gnt_given", 32'(rd_granted), 32'd1);
    repeat (2) @(negedge clk);
    #1 chk("stall_in_rd_wait", 32'(stall), 32'd1);
    reset = 1'b0;
    #1 chk_outputs_zero("mid_op_reset");
    exp_q.delete(); bus_exp.delete();
    for (int i = 0; i < N; i++) m_cfg[i] = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    gnt_delay = 0; rv_delay = 0;
    model_cfg(0, RS, 32'd0); issue(12'(VB), RS, 32'd0);
    chk("cfg0_cleared_by_reset", last_rd, 32'd0);

    // Randomized traffic
    for (int it = 0; it < 250; it++) begin
      idx = $urandom_range(0, N - 1);
      if ($urandom_range(0, 9) < 4) begin
        sel = $urandom_range(0, 9);
        if (sel < 7)      t = 12'h300 + 12'($urandom_range(0, 15));
        else if (sel < 8) t = 12'($urandom);
        else              t = 12'h100 + 12'($urandom_range(0, 31));
        wd = {10'($urandom), 5'($urandom), 5'($urandom), t};
        op = ($urandom_range(0, 9) < 7) ? RW : 2'($urandom_range(2, 3));
        model_cfg(idx, op, wd); issue(12'(VB + idx), op, wd);
      end else begin
        gnt_delay = $urandom_range(0, 3); rv_delay = $urandom_range(0, 3);
        op = 2'($urandom_range(1, 3));
        wd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        model_alias(idx, op, wd); issue(12'(VB + N + idx), op, wd);
      end
    end
    chk("bus_queue_drained", 32'(bus_exp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
